// File: rtl/two_bit_serial_subtractor_pkg.sv
// Shared types and helpers for the two-bit-per-cycle serial subtractor.
package two_bit_serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned SLICE_W = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/two_bit_borrow_slice.sv
// Combinational 2-bit subtract slice; with TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
// the same slice also adds when sub=0 (bo then carries the carry-out).
module two_bit_borrow_slice
    import two_bit_serial_subtractor_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bi,
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic               sub,
`endif
    output logic [SLICE_W-1:0] d,
    output logic               bo
);

    logic [SLICE_W:0] res;

    always_comb begin
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
        if (sub) begin
            res = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, bi};
        end else begin
            res = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, bi};
        end
`else
        res = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, bi};
`endif
    end

    assign d  = res[SLICE_W-1:0];
    assign bo = res[SLICE_W];

endmodule

// File: rtl/two_bit_serial_subtractor.sv
// Serial subtractor: diff = a - b - b_in, two bits per clock, LSB slice first.
// Optional add mode via `define TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN (adds port sub).
module two_bit_serial_subtractor
    import two_bit_serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int unsigned CNT_W = (clog2(WIDTH / 2) > 0) ? clog2(WIDTH / 2) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             bor_q, bor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic [SLICE_W-1:0] slice_d;
    logic               slice_bo;
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic             sub_q, sub_d;
`endif

    two_bit_borrow_slice u_slice (
        .a  (a_q[SLICE_W-1:0]),
        .b  (b_q[SLICE_W-1:0]),
        .bi (bor_q),
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
        .sub(sub_q),
`endif
        .d  (slice_d),
        .bo (slice_bo)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bor_d   = b_in;
                    cnt_d   = '0;
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
                    sub_d   = sub;
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // The minuend register doubles as the result accumulator: consumed
                // slices leave the bottom while result slices enter at the top.
                a_d = a_q >> SLICE_W;
                a_d[WIDTH-1 -: SLICE_W] = slice_d;
                b_d   = b_q >> SLICE_W;
                bor_d = slice_bo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = a_d;
                    bout_d  = slice_bo;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign diff  = diff_q;
    assign b_out = bout_q;

endmodule

// File: tb/tb_two_bit_serial_subtractor.sv
// Self-checking bench for two_bit_serial_subtractor (WIDTH=8): vector table,
// scoreboard queue, and hand sequences for latency, busy-ignore, streaming, reset.
module tb_two_bit_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         b_in = 1'b0;
    logic         sub = 1'b1;
    logic         busy, done, b_out;
    logic [W-1:0] diff;

    two_bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .b_in (b_in),
`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
        .sub  (sub),
`endif
        .busy (busy),
        .done (done),
        .diff (diff),
        .b_out(b_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] ed;
        logic         eb;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbi, input logic msub);
        if (msub) return {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
        else      return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mbi};
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("b_out", 32'(b_out), 32'(e.bo));
            end
            n_done++;
        end
    end

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_done < target) check("done_timeout", 32'(n_done), 32'(target));
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbi,
                          input logic [W-1:0] ed, input logic eb);
        int target;
        exp_t e;
        @(negedge clk);
        a = ta; b = tb_v; b_in = tbi; start = 1'b1;
        e.d = ed; e.bo = eb;
        exp_q.push_back(e);
        target = n_done + 1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
        wait_done(target, 20);
    endtask

    vec_t vecs[8];

    initial begin
        logic [W:0] m;
        int         ndone_snap;

        vecs[0] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[3] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[7] = '{8'h37, 8'h1C, 1'b1, 8'h1A, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
        rst = 1'b0;

        // Latency: busy for 4 cycles, done in the 5th
        @(negedge clk);
        a = 8'h05; b = 8'h03; b_in = 1'b0; start = 1'b1;
        exp_q.push_back('{8'h02, 1'b0});
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("lat_busy", 32'(busy), 32'd1);
            check("lat_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        check("lat_done5", 32'(done), 32'd1);
        check("lat_busy5", 32'(busy), 32'd0);
        #1;
        @(negedge clk);
        check("lat_done6", 32'(done), 32'd0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].ed, vecs[i].eb);
        end

        // Random vectors against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbi;
            ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
            m = model(ra, rb, rbi, 1'b1);
            run_op(ra, rb, rbi, m[W-1:0], m[W]);
        end

        // start held and operands changed during RUN are ignored
        @(negedge clk);
        a = 8'h80; b = 8'h01; b_in = 1'b0; start = 1'b1;
        exp_q.push_back('{8'h7F, 1'b0});
        ndone_snap = n_done;
        @(negedge clk);
        a = 8'h33; b = 8'h22; b_in = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("ignore_one_done", 32'(n_done - ndone_snap), 32'd1);
        check("ignore_idle_busy", 32'(busy), 32'd0);

        // Continuous start: done every 5 cycles, busy low only in DONE
        @(negedge clk);
        a = 8'h10; b = 8'h01; b_in = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{8'h0F, 1'b0});
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 15) start = 1'b0;
            check("stream_done", 32'(done), (c % 5 == 0) ? 32'd1 : 32'd0);
            check("stream_busy", 32'(busy), (c % 5 == 0) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        check("stream_idle", 32'(busy), 32'd0);

        // Reset during the 2nd RUN cycle discards the operation
        @(negedge clk);
        a = 8'h12; b = 8'h34; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_b_out", 32'(b_out), 32'd0);
        ndone_snap = n_done;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("no_done_after_rst", 32'(n_done - ndone_snap), 32'd0);
        run_op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);

`ifdef TWO_BIT_SERIAL_SUBTRACTOR_ADD_MODE_EN
        sub = 1'b0;
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        sub = 1'b1;
        run_op(8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0);
        sub = 1'b0;
        m = model(8'h7E, 8'h93, 1'b1, 1'b0);
        run_op(8'h7E, 8'h93, 1'b1, m[W-1:0], m[W]);
        sub = 1'b1;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
